// File: rtl/cordic_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : cordic_pipe
//  Purpose  : Fully pipelined CORDIC engine. Each sample selects its own mode:
//             rotation (K-scaled rotate of (x,y) by z) or vectoring
//             (K-scaled magnitude and phase of (x,y)). Valid/ready stream
//             interface with a single global stall enable.
//  Ports    : clock, reset (async, active-high)
//             in_valid/in_ready/in_mode/in_x/in_y/in_z   : input stream
//             out_valid/out_ready/out_mode/out_x/out_y/out_z : result stream
//  Revision : 1.0  initial release
// ============================================================================
module cordic_pipe #(
    parameter int XY_W = 16,
    parameter int Z_W  = 32,
    parameter int STG  = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_mode,
    input  logic signed [XY_W-1:0] in_x,
    input  logic signed [XY_W-1:0] in_y,
    input  logic signed [Z_W-1:0]  in_z,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_mode,
    output logic signed [XY_W+1:0] out_x,
    output logic signed [XY_W+1:0] out_y,
    output logic signed [Z_W-1:0]  out_z
);

    // Two guard bits cover the K*sqrt(2) growth and negation of the most
    // negative input.
    localparam int c_W = XY_W + 2;
    // Quarter turn in binary-angle units.
    localparam logic signed [Z_W-1:0] c_QTR = {2'b01, {(Z_W-2){1'b0}}};

    // atan(2^-i) in binary-angle units, rounded to nearest; evaluated only
    // at elaboration to build the per-stage constants.
    function automatic logic [Z_W-1:0] f_atan(input int i);
        real a;
        a = $atan(2.0 ** (-i)) * (2.0 ** Z_W) / (2.0 * 3.14159265358979323846);
        return Z_W'($rtoi(a + 0.5));
    endfunction

    logic                  w_en;
    logic [STG:0]          r_vld;
    logic [STG:0]          r_mode;
    logic signed [c_W-1:0] r_x [0:STG];
    logic signed [c_W-1:0] r_y [0:STG];
    logic signed [Z_W-1:0] r_z [0:STG];

    logic signed [c_W-1:0] w_xe, w_ye;
    logic signed [c_W-1:0] w_px, w_py;
    logic signed [Z_W-1:0] w_pz;

    logic signed [c_W-1:0] w_nx [1:STG];
    logic signed [c_W-1:0] w_ny [1:STG];
    logic signed [Z_W-1:0] w_nz [1:STG];

    // The whole pipe advances together; it only stalls when the last stage
    // holds a result nobody is taking.
    assign w_en     = ~r_vld[STG] | out_ready;
    assign in_ready = w_en;

    assign w_xe = {{2{in_x[XY_W-1]}}, in_x};
    assign w_ye = {{2{in_y[XY_W-1]}}, in_y};

    // Stage 0: +/-90 degree pre-rotation so the micro-rotations only need
    // to cover +/-99.9 degrees.
    always_comb begin
        w_px = w_xe;
        w_py = w_ye;
        w_pz = in_z;
        if (!in_mode) begin
            case (in_z[Z_W-1 -: 2])
                2'b01: begin
                    w_px = -w_ye;
                    w_py = w_xe;
                    w_pz = in_z - c_QTR;
                end
                2'b10: begin
                    w_px = w_ye;
                    w_py = -w_xe;
                    w_pz = in_z + c_QTR;
                end
                default: ;
            endcase
        end else if (w_xe[c_W-1]) begin
            if (!w_ye[c_W-1]) begin
                w_px = w_ye;
                w_py = -w_xe;
                w_pz = in_z + c_QTR;
            end else begin
                w_px = -w_ye;
                w_py = w_xe;
                w_pz = in_z - c_QTR;
            end
        end
    end

    // Micro-rotation i reads stage i registers and feeds stage i+1.
    for (genvar i = 0; i < STG; i++) begin : g_stage
        localparam logic signed [Z_W-1:0] c_ATAN = f_atan(i);
        logic                  w_dpos;
        logic signed [c_W-1:0] w_xs, w_ys;

        assign w_xs = r_x[i] >>> i;
        assign w_ys = r_y[i] >>> i;
        // Rotation drives z toward 0; vectoring drives y toward 0.
        assign w_dpos = r_mode[i] ? r_y[i][c_W-1] : ~r_z[i][Z_W-1];

        assign w_nx[i+1] = w_dpos ? r_x[i] - w_ys : r_x[i] + w_ys;
        assign w_ny[i+1] = w_dpos ? r_y[i] + w_xs : r_y[i] - w_xs;
        assign w_nz[i+1] = w_dpos ? r_z[i] - c_ATAN : r_z[i] + c_ATAN;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_vld  <= '0;
            r_mode <= '0;
            for (int s = 0; s <= STG; s++) begin
                r_x[s] <= '0;
                r_y[s] <= '0;
                r_z[s] <= '0;
            end
        end else if (w_en) begin
            r_vld  <= {r_vld[STG-1:0], in_valid};
            r_mode <= {r_mode[STG-1:0], in_mode};
            r_x[0] <= w_px;
            r_y[0] <= w_py;
            r_z[0] <= w_pz;
            for (int s = 1; s <= STG; s++) begin
                r_x[s] <= w_nx[s];
                r_y[s] <= w_ny[s];
                r_z[s] <= w_nz[s];
            end
        end
    end

    assign out_valid = r_vld[STG];
    assign out_mode  = r_mode[STG];
    assign out_x     = r_x[STG];
    assign out_y     = r_y[STG];
    assign out_z     = r_z[STG];

endmodule
`default_nettype wire

// File: tb/tb_cordic_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cordic_pipe
//  Purpose  : Directed self-checking bench for cordic_pipe (XY_W=16, Z_W=32,
//             STG=16): rotation/vectoring accuracy, quadrant pre-rotation,
//             latency, streaming order, backpressure and mid-stream reset.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cordic_pipe;

    localparam int  XY_W = 16;
    localparam int  Z_W  = 32;
    localparam int  STG  = 16;
    localparam int  LAT  = STG + 1;
    localparam real K    = 1.6467602581;
    localparam longint TOL_XY = 10;

    logic                   clock = 1'b0;
    logic                   reset;
    logic                   in_valid;
    logic                   in_ready;
    logic                   in_mode;
    logic signed [XY_W-1:0] in_x, in_y;
    logic signed [Z_W-1:0]  in_z;
    logic                   out_valid;
    logic                   out_ready;
    logic                   out_mode;
    logic signed [XY_W+1:0] out_x, out_y;
    logic signed [Z_W-1:0]  out_z;

    always #5 clock = ~clock;

    cordic_pipe #(.XY_W(XY_W), .Z_W(Z_W), .STG(STG)) dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_mode  (in_mode),
        .in_x     (in_x),
        .in_y     (in_y),
        .in_z     (in_z),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_mode (out_mode),
        .out_x    (out_x),
        .out_y    (out_y),
        .out_z    (out_z)
    );

    typedef struct {
        longint x;
        longint y;
        longint z;
        logic   m;
        int     cyc;
    } rec_t;

    rec_t out_q[$];
    int   acc_q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    // Transfers are logged at the falling edge, where inputs and outputs
    // are both settled for the upcoming rising edge.
    always @(negedge clock) begin
        rec_t r;
        cyc++;
        if (!reset) begin
            if (in_valid && in_ready) acc_q.push_back(cyc);
            if (out_valid && out_ready) begin
                r.x = out_x; r.y = out_y; r.z = out_z; r.m = out_mode; r.cyc = cyc;
                out_q.push_back(r);
            end
        end
    end

    task automatic check(input string tag, input longint got, input longint exp, input longint tol);
        longint d;
        checks++;
        d = got - exp;
        if (d < 0) d = -d;
        if (d > tol) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d +/- %0d", tag, got, exp, tol);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic m, input int x, input int y, input logic [31:0] z);
        bit acc;
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_mode  = m;
        in_x     = XY_W'(x);
        in_y     = XY_W'(y);
        in_z     = z;
        do begin
            @(negedge clock);
            acc = in_ready;
            tick();
            guard++;
        end while (!acc && guard < 200);
        if (!acc) check("send_timeout", 0, 1, 0);
    endtask

    task automatic get(output rec_t r, output int lat);
        int guard;
        guard = 0;
        while (out_q.size() == 0 && guard < 200) begin
            tick();
            guard++;
        end
        if (out_q.size() == 0) begin
            check("out_timeout", 0, 1, 0);
            r   = '{default: 0};
            lat = -1;
        end else begin
            r   = out_q.pop_front();
            lat = (acc_q.size() > 0) ? r.cyc - acc_q.pop_front() : -1;
        end
    endtask

    task automatic wait_count(input int n);
        int guard;
        guard = 0;
        while (out_q.size() < n && guard < 300) begin
            tick();
            guard++;
        end
    endtask

    // Gain-scaled magnitude of an on-axis input.
    function automatic longint kx(input int v);
        return longint'(K * v);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

    initial begin
        rec_t r;
        int   lat;
        logic signed [XY_W+1:0] sx, sy;
        logic signed [Z_W-1:0]  sz;
        logic                   sm;

        reset = 1'b1; in_valid = 1'b0; in_mode = 1'b0;
        in_x = '0; in_y = '0; in_z = '0; out_ready = 1'b1;

        // Reset state
        repeat (2) tick();
        check("rst_out_valid", out_valid, 0, 0);
        check("rst_out_x", out_x, 0, 0);
        check("rst_out_y", out_y, 0, 0);
        check("rst_out_z", out_z, 0, 0);
        check("rst_out_mode", out_mode, 0, 0);
        check("rst_in_ready", in_ready, 1, 0);
        reset = 1'b0;
        repeat (2) tick();

        // Rotation by 30 degrees: K*19429 = 31994.9
        send(1'b0, 19429, 0, 32'h15555555);
        in_valid = 1'b0;
        get(r, lat);
        check("rot30_latency", lat, LAT, 0);
        check("rot30_x", r.x, 27708, TOL_XY);
        check("rot30_y", r.y, 15998, TOL_XY);
        check("rot30_z", r.z, 0, 131071);
        check("rot30_mode", r.m, 0, 0);

        // Quadrant pre-rotation: +120 and -120 degrees
        send(1'b0, 19429, 0, 32'h55555555);
        in_valid = 1'b0;
        get(r, lat);
        check("rot120_x", r.x, -15998, TOL_XY);
        check("rot120_y", r.y, 27708, TOL_XY);
        send(1'b0, 19429, 0, 32'hAAAAAAAB);
        in_valid = 1'b0;
        get(r, lat);
        check("rotm120_x", r.x, -15998, TOL_XY);
        check("rotm120_y", r.y, -27708, TOL_XY);
        check("rotm120_z", r.z, 0, 131071);

        // Vectoring (-3000, 4000): |v|=5000, phase 126.87 degrees
        send(1'b1, -3000, 4000, 32'h0);
        in_valid = 1'b0;
        get(r, lat);
        check("vec_latency", lat, LAT, 0);
        check("vec_x", r.x, 8234, TOL_XY);
        check("vec_y", r.y, 0, TOL_XY);
        check("vec_z", r.z, 1513616834, 262144);
        check("vec_mode", r.m, 1, 0);
        out_q.delete(); acc_q.delete();

        // Streaming: 20 back-to-back samples, alternating modes
        for (int i = 0; i < 20; i++) send(i[0], 1000 + 500 * i, 0, 32'h0);
        in_valid = 1'b0;
        wait_count(20);
        repeat (5) tick();
        check("stream_count", out_q.size(), 20, 0);
        if (out_q.size() == 20 && acc_q.size() > 0) begin
            check("stream_latency", out_q[0].cyc - acc_q[0], LAT, 0);
            for (int i = 0; i < 20; i++) begin
                check($sformatf("stream_x[%0d]", i), out_q[i].x, kx(1000 + 500 * i), TOL_XY);
                check($sformatf("stream_mode[%0d]", i), out_q[i].m, i % 2, 0);
                check($sformatf("stream_cyc[%0d]", i), out_q[i].cyc, out_q[0].cyc + i, 0);
            end
        end
        out_q.delete(); acc_q.delete();

        // Backpressure: stall 5 cycles with a valid result and a pending input
        for (int i = 0; i < 18; i++) send(i[0], 2000 + 300 * i, 0, 32'h0);
        check("bp_pre_valid", out_valid, 1, 0);
        in_valid = 1'b1; in_mode = 1'b0; in_x = XY_W'(2000 + 300 * 18); in_y = '0; in_z = '0;
        out_ready = 1'b0;
        #1;
        sx = out_x; sy = out_y; sz = out_z; sm = out_mode;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            check("bp_in_ready", in_ready, 0, 0);
            check("bp_out_valid", out_valid, 1, 0);
            check("bp_stable", (out_x == sx && out_y == sy && out_z == sz && out_mode == sm), 1, 0);
            tick();
        end
        out_ready = 1'b1;
        for (int i = 18; i < 25; i++) send(i[0], 2000 + 300 * i, 0, 32'h0);
        in_valid = 1'b0;
        wait_count(25);
        repeat (20) tick();
        check("bp_count", out_q.size(), 25, 0);
        if (out_q.size() == 25) begin
            for (int i = 0; i < 25; i++) begin
                check($sformatf("bp_x[%0d]", i), out_q[i].x, kx(2000 + 300 * i), TOL_XY);
                check($sformatf("bp_mode[%0d]", i), out_q[i].m, i % 2, 0);
            end
        end
        out_q.delete(); acc_q.delete();

        // Reset mid-stream with 8 samples in flight
        for (int i = 0; i < 8; i++) send(1'b0, 3000 + 100 * i, 0, 32'h0);
        in_valid = 1'b0;
        repeat (9) tick();
        check("mid_pre_valid", out_valid, 1, 0);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_valid", out_valid, 0, 0);
        check("mid_rst_x", out_x, 0, 0);
        check("mid_rst_y", out_y, 0, 0);
        check("mid_rst_z", out_z, 0, 0);
        check("mid_rst_mode", out_mode, 0, 0);
        out_q.delete(); acc_q.delete();
        repeat (2) tick();
        reset = 1'b0;
        check("mid_rel_ready", in_ready, 1, 0);
        repeat (30) tick();
        check("mid_no_stale", out_q.size(), 0, 0);
        send(1'b1, -3000, 4000, 32'h0);
        in_valid = 1'b0;
        get(r, lat);
        check("mid_new_latency", lat, LAT, 0);
        check("mid_new_x", r.x, 8234, TOL_XY);
        check("mid_new_mode", r.m, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
